// File: rtl/pipe_stall_if.sv
// pipe_stall_if: bundles the hazard/branch/SRAM status inputs and the per-register pipeline
// controls exchanged between the pipeline datapath and pipe_stall_ctrl.
//   master : pipeline side, drives hazard_detected, branch_taken, mem_req, sram_ready
//            and receives the freeze/flush/bubble controls, mem_error and the counters.
//   slave  : pipe_stall_ctrl side, the mirror image of master.
// Parameter CNT_W must match the CNT_W of the attached pipe_stall_ctrl.
interface pipe_stall_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             hazard_detected;
    logic             branch_taken;
    logic             mem_req;
    logic             sram_ready;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             freeze_id_ex;
    logic             freeze_ex_mem;
    logic             flush_if_id;
    logic             bubble_id_ex;
    logic             bubble_mem_wb;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output hazard_detected, branch_taken, mem_req, sram_ready,
        input  freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem,
        input  flush_if_id, bubble_id_ex, bubble_mem_wb, mem_error, stall_cnt, flush_cnt
    );

    modport slave (
        input  hazard_detected, branch_taken, mem_req, sram_ready,
        output freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem,
        output flush_if_id, bubble_id_ex, bubble_mem_wb, mem_error, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: turns load-use hazards, taken branches and SRAM waits into freeze, flush
// and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-low reset; forces every control output to 0 while low
//   bus  : pipe_stall_if.slave carrying the status inputs, the controls, the sticky
//          mem_error flag and the saturating stall_cnt / flush_cnt counters
// Controls are combinational from state and current inputs (act in the same cycle).
// A memory wait longer than MAX_WAIT cycles locks the controller in StMemErr until reset.
module pipe_stall_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned WAIT_W   = 7
) (
    input logic        clk,
    input logic        rst,
    pipe_stall_if.slave bus
);

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StMemErr
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               mem_error_q, mem_error_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    // Ungated stall sources; combined with rst below.
    logic mem_stall;
    logic br_flush;
    logic ld_stall;

    logic freeze_pc;
    logic flush_if_id;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_stall = 1'b0;
        br_flush  = 1'b0;
        ld_stall  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.mem_req && !bus.sram_ready) begin
                    mem_stall = 1'b1;
                    state_d   = StMemWait;
                    wait_d    = WAIT_W'(1);
                end else if (bus.branch_taken) begin
                    br_flush = 1'b1;
                end else if (bus.hazard_detected) begin
                    ld_stall = 1'b1;
                end
            end
            StMemWait: begin
                if (!bus.sram_ready) begin
                    mem_stall = 1'b1;
                    if (wait_q == WAIT_W'(MAX_WAIT)) begin
                        state_d = StMemErr;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end else begin
                    // Access completes: pipeline advances, branch/hazard act this cycle.
                    state_d = StRun;
                    wait_d  = '0;
                    if (bus.branch_taken) begin
                        br_flush = 1'b1;
                    end else if (bus.hazard_detected) begin
                        ld_stall = 1'b1;
                    end
                end
            end
            StMemErr: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = StRun;
                wait_d  = '0;
            end
        endcase
    end

    assign mem_error_d = mem_error_q | (state_d == StMemErr);

    assign freeze_pc   = rst & (mem_stall | ld_stall);
    assign flush_if_id = rst & br_flush;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (freeze_pc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_if_id && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            wait_q      <= '0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_error_q <= mem_error_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.freeze_pc     = freeze_pc;
    assign bus.freeze_if_id  = freeze_pc;
    assign bus.freeze_id_ex  = rst & mem_stall;
    assign bus.freeze_ex_mem = rst & mem_stall;
    assign bus.flush_if_id   = flush_if_id;
    assign bus.bubble_id_ex  = rst & (br_flush | ld_stall);
    assign bus.bubble_mem_wb = rst & mem_stall;
    assign bus.mem_error     = mem_error_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed and random stimulus for pipe_stall_ctrl with CNT_W=3 and
// MAX_WAIT=4. A driver issues one input set per cycle and queues the expected outputs from a
// behavioural model; a monitor pops and compares on each falling edge.
module tb_pipe_stall_ctrl;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned WAIT_W   = 7;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0]       ctl;   // fpc,fifid,fidex,fexmem,flush,bub_idex,bub_memwb,mem_error
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic clk;
    logic rst;

    pipe_stall_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_ctrl #(
        .CNT_W   (CNT_W),
        .MAX_WAIT(MAX_WAIT),
        .WAIT_W  (WAIT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    // Reference model: length of the pending memory access, lock-up flag, counters.
    int m_waits;
    bit m_err;
    int m_sc;
    int m_fc;

    task automatic model_reset();
        m_waits = 0;
        m_err   = 1'b0;
        m_sc    = 0;
        m_fc    = 0;
    endtask

    task automatic drive(input logic hz, input logic br, input logic rq, input logic rd);
        bus.hazard_detected = hz;
        bus.branch_taken    = br;
        bus.mem_req         = rq;
        bus.sram_ready      = rd;
    endtask

    task automatic step(input logic hz, input logic br, input logic rq, input logic rd);
        exp_t e;
        bit   ms, fl, ls, nerr;
        @(posedge clk);
        #1;
        drive(hz, br, rq, rd);
        rst = 1'b1;
        ms = 0; fl = 0; ls = 0; nerr = 0;
        if (m_err) begin
            ms = 1;
        end else if ((m_waits > 0 || rq) && !rd) begin
            ms = 1;
            m_waits++;
            if (m_waits > MAX_WAIT) nerr = 1;
        end else begin
            m_waits = 0;
            if (br) fl = 1;
            else if (hz) ls = 1;
        end
        e.ctl = {ms | ls, ms | ls, ms, ms, fl, fl | ls, ms, m_err};
        e.sc  = CNT_W'(m_sc);
        e.fc  = CNT_W'(m_fc);
        exp_q.push_back(e);
        if (ms | ls) m_sc = (m_sc + 1 > CNT_MAX) ? CNT_MAX : m_sc + 1;
        if (fl)      m_fc = (m_fc + 1 > CNT_MAX) ? CNT_MAX : m_fc + 1;
        m_err = m_err | nerr;
    endtask

    // Reset asserted mid-cycle with arbitrary inputs: everything must read 0 at once.
    task automatic pulse_reset(input logic hz, input logic br, input logic rq, input logic rd);
        exp_t e;
        @(posedge clk);
        #1;
        drive(hz, br, rq, rd);
        rst = 1'b0;
        e = '0;
        exp_q.push_back(e);
        model_reset();
    endtask

    task automatic repeat_step(input int n, input logic hz, input logic br, input logic rq,
                               input logic rd);
        for (int i = 0; i < n; i++) step(hz, br, rq, rd);
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.freeze_pc, bus.freeze_if_id, bus.freeze_id_ex, bus.freeze_ex_mem,
                       bus.flush_if_id, bus.bubble_id_ex, bus.bubble_mem_wb, bus.mem_error};
                total++;
                if (act !== e.ctl) begin
                    bad++;
                    $display("FAIL controls @%0t: got %b want %b", $time, act, e.ctl);
                end
                total++;
                if (bus.stall_cnt !== e.sc) begin
                    bad++;
                    $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, bus.stall_cnt, e.sc);
                end
                total++;
                if (bus.flush_cnt !== e.fc) begin
                    bad++;
                    $display("FAIL flush_cnt @%0t: got %0d want %0d", $time, bus.flush_cnt, e.fc);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();

        // Reset state, then idle.
        pulse_reset(0, 0, 0, 0);
        repeat_step(2, 0, 0, 0, 0);

        // Single and repeated load-use stalls.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat_step(3, 1, 0, 0, 0);
        step(0, 0, 0, 0);

        // Branch wins over hazard; zero-wait access.
        pulse_reset(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        // Four wait cycles, ready lands exactly when the wait count hits MAX_WAIT.
        pulse_reset(0, 0, 0, 0);
        repeat_step(4, 0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        // Ready cycle with a branch: freezes drop and the flush acts in the same cycle.
        repeat_step(2, 1, 1, 1, 0);
        step(1, 1, 1, 1);
        step(1, 0, 0, 0);

        // Timeout: never ready, then ready ignored, then reset clears.
        pulse_reset(0, 0, 0, 0);
        repeat_step(8, 0, 0, 1, 0);
        repeat_step(3, 1, 1, 1, 1);
        pulse_reset(1, 0, 1, 0);
        step(0, 0, 0, 0);

        // flush_cnt saturation.
        repeat_step(10, 0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Reset during a memory wait.
        pulse_reset(0, 0, 0, 0);
        repeat_step(2, 0, 0, 1, 0);
        pulse_reset(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0));
            end
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
